// File: rtl/clint_bus_if.sv
// Native memory bus between an initiator and the CLINT responder:
// valid/ready handshake with byte-lane write strobes.
interface clint_bus_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/clint_bus_responder.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime behind
// a one-wait-state bus responder, producing the software and timer interrupts.
module clint_bus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    clint_bus_if.slave  bus,
    output logic        sel,
    output logic        IRQ3,
    output logic        IRQ7,
    output logic [63:0] mtime_o
);

    localparam logic [31:0] PRESC_LAST   = 32'(TICK_DIV - 1);
    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTCMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTCMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic [31:0] presc_q, presc_d;
    logic        irq3_q, irq3_d;
    logic        irq7_q, irq7_d;

    logic        accept_s;
    logic        tick_s;
    logic [31:0] read_data_s;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Window decode, visible to the interconnect in the same cycle.
    always_comb begin
        sel = bus.mem_valid && (bus.mem_addr[31:16] == BASE_ADDR[31:16]);
    end

    // Read mux over the current register values.
    always_comb begin
        case (bus.mem_addr[15:0])
            OFF_MSIP:     read_data_s = {31'h0000_0000, msip_q};
            OFF_MTCMP_LO: read_data_s = mtimecmp_q[31:0];
            OFF_MTCMP_HI: read_data_s = mtimecmp_q[63:32];
            OFF_MTIME_LO: read_data_s = mtime_q[31:0];
            OFF_MTIME_HI: read_data_s = mtime_q[63:32];
            default:      read_data_s = 32'h0000_0000;
        endcase
    end

    // Next-state: handshake FSM, register writes, prescaler and interrupts.
    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        rdata_d    = 32'h0000_0000;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        irq3_d     = msip_q;
        irq7_d     = (mtime_q >= mtimecmp_q);

        accept_s = (state_q == ST_IDLE) && sel;
        tick_s   = (presc_q == PRESC_LAST);
        presc_d  = tick_s ? 32'd0 : (presc_q + 32'd1);
        mtime_d  = tick_s ? (mtime_q + 64'd1) : mtime_q;

        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept_s) begin
            ready_d = 1'b1;
            if (bus.mem_wstrb == 4'b0000) begin
                rdata_d = read_data_s;
            end else begin
                // A write to mtime replaces the unincremented value, so any tick this cycle is lost.
                case (bus.mem_addr[15:0])
                    OFF_MSIP: begin
                        if (bus.mem_wstrb[0]) begin
                            msip_d = bus.mem_wdata[0];
                        end else begin
                            msip_d = msip_q;
                        end
                    end
                    OFF_MTCMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], bus.mem_wdata, bus.mem_wstrb);
                    OFF_MTCMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.mem_wdata, bus.mem_wstrb);
                    OFF_MTIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.mem_wdata, bus.mem_wstrb)};
                    OFF_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], bus.mem_wdata, bus.mem_wstrb), mtime_q[31:0]};
                    default:      msip_d = msip_q;
                endcase
            end
        end else begin
            ready_d = 1'b0;
        end
    end

    // State register; reset overrides any request or tick in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            msip_q     <= 1'b0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q    <= 64'h0000_0000_0000_0000;
            presc_q    <= 32'd0;
            irq3_q     <= 1'b0;
            irq7_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            presc_q    <= presc_d;
            irq3_q     <= irq3_d;
            irq7_q     <= irq7_d;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign IRQ3          = irq3_q;
    assign IRQ7          = irq7_q;
    assign mtime_o       = mtime_q;

endmodule

// File: doc/clint_bus_responder.md
CLINT_BUS_RESPONDER -- requirements
Module: clint_bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, the base of the 64 KiB register window.
REQ-002 SHALL have parameter TICK_DIV, default 1, the number of clk cycles per mtime increment (legal range >= 1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-005 SHALL have port mem_valid, input, 1 bit, a request held by the initiator until mem_ready is seen.
REQ-006 SHALL have port mem_ready, output, 1 bit, a single-cycle response pulse.
REQ-007 SHALL have port mem_addr, input, 32 bits, the byte address of the request.
REQ-008 SHALL have port mem_wstrb, input, 4 bits, the byte-lane write strobes; all zero means a read.
REQ-009 SHALL have port mem_wdata, input, 32 bits, the write data.
REQ-010 SHALL have port mem_rdata, output, 32 bits, the read data, valid while mem_ready is high.
REQ-011 SHALL have port sel, output, 1 bit, asserted combinationally when mem_valid is high and mem_addr[31:16] equals BASE_ADDR[31:16].
REQ-012 SHALL have port IRQ3, output, 1 bit, the machine software interrupt.
REQ-013 SHALL have port IRQ7, output, 1 bit, the machine timer interrupt.
REQ-014 SHALL have port mtime_o, output, 64 bits, the current mtime value, for the time/timeh CSRs.

Function
REQ-015 SHALL map the following registers at the given offsets from BASE_ADDR:
- 0x0000: msip (bit0 only; bits 31:1 read as 0).
- 0x4000 / 0x4004: mtimecmp low / high.
- 0xBFF8 / 0xBFFC: mtime low / high.
- Any other offset in the window reads 0; writes to it are ignored.
REQ-016 SHALL implement a 2-state FSM:
- IDLE -> RESP when sel=1.
- RESP -> IDLE unconditionally.
- In IDLE, mem_valid is not sampled unless sel=1.
REQ-017 SHALL accept a request in the IDLE cycle in which sel=1:
- Writes take effect at that clock edge, per byte lane where mem_wstrb[i]=1.
- Read data is registered into mem_rdata at that same edge.
REQ-018 SHALL drive mem_ready=1 for exactly the RESP cycle, giving 1 wait state; back-to-back requests complete every 2 cycles.
REQ-019 SHALL drive mem_rdata=0 whenever mem_ready=0; a write access returns mem_rdata=0.
REQ-020 SHALL keep mem_ready=0 indefinitely for requests with sel=0, leaving them to other responders.
REQ-021 SHALL handle prescaling and mtime increment as follows:
- A prescaler counts 0..TICK_DIV-1, and mtime increments by 1 when the prescaler wraps to 0.
- With TICK_DIV=1, mtime increments every cycle.
REQ-022 SHALL wrap mtime from 2^64-1 to 0 with no other effect.
REQ-023 SHALL resolve a write to mtime low or high in the same cycle as a tick as follows:
- The write wins: the new mtime is the current (unincremented) value with the written bytes replaced.
- That tick is dropped.
- The prescaler keeps counting.
REQ-024 SHALL register IRQ7 each cycle as the unsigned 64-bit comparison (mtime >= mtimecmp) on current register values, so IRQ7 lags a register change by 1 cycle.
REQ-025 SHALL register IRQ3 as msip[0], so IRQ3 changes 1 cycle after the accepting edge.
REQ-026 SHALL NOT snapshot the 64-bit registers between a low read and a high read; software handles tearing.
REQ-027 SHALL drive mtime_o equal to the mtime register with no added latency.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, set the following regardless of state:
- FSM = IDLE, mem_ready=0, mem_rdata=0.
- msip=0, mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
- IRQ3=0, IRQ7=0.
REQ-029 SHALL give reset priority over any simultaneous request or tick.
REQ-030 SHALL, if reset occurs in RESP, give no mem_ready pulse for that request; a write accepted before the reset is still overwritten by the reset values.
REQ-031 SHALL NOT accept a request in the cycle reset is high.

Verification
REQ-032 SHALL cover: release reset; read BASE+0x4000 and BASE+0x4004 -> both 0xFFFFFFFF; IRQ3=0; IRQ7=0.
REQ-033 SHALL cover: write 1 to BASE+0x0000 with wstrb=4'hF -> mem_ready 1 cycle later; IRQ3=1 from the cycle after accept; write 0 -> IRQ3=0.
REQ-034 SHALL cover: TICK_DIV=4, reset released at cycle 0 -> mtime_o=10 at cycle 40; a read of BASE+0xBFF8 returns the value mtime had at the accepting edge.
REQ-035 SHALL cover: write mtimecmp high=0 and low=0x20 with mtime < 0x20 -> IRQ7 rises exactly 1 cycle after mtime_o reaches 0x20; writing mtimecmp low=0xFFFFFFFF clears IRQ7 1 cycle later.
REQ-036 SHALL cover: write wstrb=4'b0010, wdata=0x0000AB00 to BASE+0x4000 after reset -> readback 0xFFFFABFF.
REQ-037 SHALL cover: write mtime low and high = 0xFFFFFFFF with TICK_DIV=1 -> mtime_o = 0 after the next tick; an access to 0x1000_0000 -> sel=0 and mem_ready stays 0 for 100 cycles.
